// File: rtl/sm_result_acc4.sv
// Block accumulator for 4-bit add/subtract results; presents each block total in sign-magnitude.
// Build option: define SM_RESULT_ACC4_SAT_EN to saturate the accumulator instead of wrapping.
module sm_result_acc4 #(
   parameter int ACC_W     = 8,
   parameter int BLOCK_LEN = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_type,
   input  logic             in_carry,
   input  logic [3:0]       in_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_neg,
   output logic [ACC_W-1:0] out_mag,
   output logic             out_ovf,
   output logic             out_err
);
   // state | meaning
   // ACC   | accepting words, summing into acc
   // HOLD  | block total presented, waiting for consumer handshake
   typedef enum logic {ST_ACC, ST_HOLD} state_t;

   localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] count;
   logic             ovf_r;
   logic             err_r;

   logic [5:0]       v;
   logic             err_word;
   logic [ACC_W:0]   v_ext;
   logic [ACC_W:0]   sum_x;
   logic             ovf_now;
   logic [ACC_W-1:0] acc_nxt;
   logic [ACC_W-1:0] mag_nxt;
   logic             accept;

   assign in_ready  = (state == ST_ACC);
   assign out_valid = (state == ST_HOLD);
   assign accept    = in_valid && in_ready;

   always_comb begin
      v        = '0;
      err_word = 1'b0;
      if (in_type) begin
         v = {1'b0, in_carry, in_result};
      end else if (in_carry) begin
         v        = -{2'b00, in_result};
         err_word = (in_result == 4'd0);
      end else begin
         v = {2'b00, in_result};
      end
   end

   // One guard bit above the accumulator exposes the true sign of the sum.
   assign v_ext   = {{(ACC_W-5){v[5]}}, v};
   assign sum_x   = {acc[ACC_W-1], acc} + v_ext;
   assign ovf_now = sum_x[ACC_W] ^ sum_x[ACC_W-1];

`ifdef SM_RESULT_ACC4_SAT_EN
   always_comb begin
      acc_nxt = sum_x[ACC_W-1:0];
      if (ovf_now)
         acc_nxt = sum_x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
   end
`else
   assign acc_nxt = sum_x[ACC_W-1:0];
`endif

   // Most-negative value negates to itself, which reads correctly as unsigned 2^(ACC_W-1).
   assign mag_nxt = acc_nxt[ACC_W-1] ? (~acc_nxt + ACC_W'(1)) : acc_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_ACC;
         acc     <= '0;
         count   <= '0;
         ovf_r   <= 1'b0;
         err_r   <= 1'b0;
         out_neg <= 1'b0;
         out_mag <= '0;
         out_ovf <= 1'b0;
         out_err <= 1'b0;
      end else begin
         case (state)
            ST_ACC: begin
               if (accept) begin
                  acc   <= acc_nxt;
                  ovf_r <= ovf_r | ovf_now;
                  err_r <= err_r | err_word;
                  if (count == LAST) begin
                     out_neg <= acc_nxt[ACC_W-1];
                     out_mag <= mag_nxt;
                     out_ovf <= ovf_r | ovf_now;
                     out_err <= err_r | err_word;
                     state   <= ST_HOLD;
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  acc   <= '0;
                  count <= '0;
                  ovf_r <= 1'b0;
                  err_r <= 1'b0;
                  state <= ST_ACC;
               end
            end
            default: state <= ST_ACC;
         endcase
      end
   end
endmodule

// File: tb/tb_sm_result_acc4.sv
// Directed bench for sm_result_acc4 with default parameters (ACC_W=8, BLOCK_LEN=8).
module tb_sm_result_acc4;
   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic       in_type;
   logic       in_carry;
   logic [3:0] in_result;
   logic       out_valid;
   logic       out_ready;
   logic       out_neg;
   logic [7:0] out_mag;
   logic       out_ovf;
   logic       out_err;

   int checks = 0;
   int errors = 0;

   sm_result_acc4 #(.ACC_W(8), .BLOCK_LEN(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_type(in_type), .in_carry(in_carry), .in_result(in_result),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_neg(out_neg), .out_mag(out_mag), .out_ovf(out_ovf), .out_err(out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // word = {type, carry, result}
   task automatic send_word(input logic [5:0] w);
      int n;
      in_valid = 1'b1;
      {in_type, in_carry, in_result} = w;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 20) check("in_ready_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      in_type   = 1'b1;
      in_carry  = 1'b1;
      in_result = 4'hF;
   endtask

   task automatic send_block(input logic [7:0][5:0] words, input string tag,
                             input logic neg, input logic [7:0] mag,
                             input logic ovf, input logic err);
      for (int i = 0; i < 8; i++) begin
         send_word(words[i]);
         if (i < 7) check({tag, "_early_valid"}, out_valid, 0);
      end
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_neg"}, out_neg, neg);
      check({tag, "_mag"}, out_mag, mag);
      check({tag, "_ovf"}, out_ovf, ovf);
      check({tag, "_err"}, out_err, err);
   endtask

   task automatic pop_block(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_pop_valid"}, out_valid, 0);
      check({tag, "_pop_ready"}, in_ready, 1);
   endtask

   function automatic logic [7:0][5:0] uniform(input logic [5:0] w);
      logic [7:0][5:0] b;
      for (int i = 0; i < 8; i++) b[i] = w;
      return b;
   endfunction

   logic [7:0][5:0] blk;

   initial begin
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_type = 1'b0; in_carry = 1'b0; in_result = 4'd0;
      #1 rst_n = 1'b0;
      #12;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_neg", out_neg, 0);
      check("rst_out_mag", out_mag, 0);
      check("rst_out_ovf", out_ovf, 0);
      check("rst_out_err", out_err, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // 3 + 2 - 2 + 30 = 33
      blk = uniform(6'b1_0_0000);
      blk[0] = 6'b1_0_0011; blk[1] = 6'b0_0_0010; blk[2] = 6'b0_1_0010; blk[3] = 6'b1_1_1110;
      send_block(blk, "mixed", 1'b0, 8'd33, 1'b0, 1'b0);
      pop_block("mixed");

      send_block(uniform(6'b0_1_1111), "neg120", 1'b1, 8'd120, 1'b0, 1'b0);
      pop_block("neg120");

`ifdef SM_RESULT_ACC4_SAT_EN
      send_block(uniform(6'b1_1_1110), "ovf", 1'b0, 8'd127, 1'b1, 1'b0);
`else
      send_block(uniform(6'b1_1_1110), "ovf", 1'b1, 8'd16, 1'b1, 1'b0);
`endif

      // back-pressure in HOLD: words offered must not be counted, outputs frozen
      in_valid = 1'b1; in_type = 1'b1; in_carry = 1'b0; in_result = 4'd5;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_in_ready", in_ready, 0);
         check("bp_out_valid", out_valid, 1);
`ifdef SM_RESULT_ACC4_SAT_EN
         check("bp_mag", out_mag, 127);
         check("bp_neg", out_neg, 0);
`else
         check("bp_mag", out_mag, 16);
         check("bp_neg", out_neg, 1);
`endif
         check("bp_ovf", out_ovf, 1);
      end
      in_valid = 1'b0;
      pop_block("bp");

      blk = uniform(6'b1_0_0001);
      blk[2] = 6'b0_1_0000;
      send_block(blk, "err", 1'b0, 8'd7, 1'b0, 1'b1);
      pop_block("err");

      send_block(uniform(6'b1_0_0001), "clean", 1'b0, 8'd8, 1'b0, 1'b0);
      pop_block("clean");

      // reset mid-block discards the partial sum
      for (int i = 0; i < 3; i++) send_word(6'b1_0_0101);
      rst_n = 1'b0;
      #2;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      @(posedge clk); #1 rst_n = 1'b1;
      send_block(uniform(6'b1_0_0001), "after_rst", 1'b0, 8'd8, 1'b0, 1'b0);

      // reset during HOLD drops out_valid without a clock edge
      #2 rst_n = 1'b0;
      #1;
      check("holdrst_out_valid", out_valid, 0);
      check("holdrst_out_mag", out_mag, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      send_block(uniform(6'b0_0_0011), "post_hold_rst", 1'b0, 8'd24, 1'b0, 1'b0);
      pop_block("post_hold_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
